// File: rtl/dm_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with an AXI4-Lite master port.
// Optional build macro DM_CACHE_BYPASS_EN: addresses in the UNCACHED_PREFIX region never hit or fill.
module dm_cache #(
    parameter int          NLINES          = 256,
    parameter logic [3:0]  UNCACHED_PREFIX = 4'hF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        request_enable,
    input  logic        req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic        flush,
    output logic        response_enable,
    output logic [31:0] resp_data,
    output logic [31:0] axi_araddr,
    output logic        axi_arvalid,
    output logic [2:0]  axi_arprot,
    input  logic        axi_arready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    output logic [31:0] axi_awaddr,
    output logic        axi_awvalid,
    output logic [2:0]  axi_awprot,
    input  logic        axi_awready,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    input  logic [1:0]  axi_bresp,
    input  logic        axi_bvalid,
    output logic        axi_bready
);
    localparam int   IDX         = $clog2(NLINES);
    localparam int   TAGW        = 30 - IDX;
    localparam logic MEMREQ_READ = 1'b0;

    typedef enum logic [2:0] {IDLE, AR_WAIT, R_WAIT, W_WAIT, B_WAIT, RESPOND} state_t;
    typedef struct packed {
        logic [29:0] waddr;
        logic        uncached;
    } req_t;

    state_t             state;
    req_t               cap;
    logic               flush_pend;
    logic [NLINES-1:0]  valid;
    logic [TAGW-1:0]    tag_arr  [NLINES];
    logic [31:0]        data_arr [NLINES];

    logic [IDX-1:0]     idx, fidx;
    logic [TAGW-1:0]    tag, ftag;
    logic               uncached, hit, fill_en, merge_en;
    logic [31:0]        merged;
    logic               unused_bits;

    assign idx  = req_addr[IDX+1:2];
    assign tag  = req_addr[31:IDX+2];
    assign fidx = cap.waddr[IDX-1:0];
    assign ftag = cap.waddr[29:IDX];

`ifdef DM_CACHE_BYPASS_EN
    assign uncached = (req_addr[31:28] == UNCACHED_PREFIX);
`else
    assign uncached = 1'b0;
`endif

    assign unused_bits = ^{req_addr[1:0], axi_bresp, UNCACHED_PREFIX};

    // A pending flush makes the IDLE lookup see the array as already cleared.
    assign hit      = valid[idx] && (tag_arr[idx] == tag) && !flush_pend && !uncached;
    assign fill_en  = (state == R_WAIT) && axi_rvalid && (axi_rresp == 2'b00) && !cap.uncached;
    assign merge_en = (state == IDLE) && request_enable && (req_mode != MEMREQ_READ) && hit;

    always_comb begin
        merged = data_arr[idx];
        for (int b = 0; b < 4; b++)
            if (req_wstrb[b]) merged[8*b +: 8] = req_wdata[8*b +: 8];
    end

    assign axi_arprot = 3'b000;
    assign axi_awprot = 3'b000;

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_arr[fidx]  <= ftag;
            data_arr[fidx] <= axi_rdata;
        end else if (merge_en) begin
            data_arr[idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            cap             <= '0;
            flush_pend      <= 1'b0;
            valid           <= '0;
            response_enable <= 1'b0;
            resp_data       <= '0;
            axi_araddr      <= '0;
            axi_arvalid     <= 1'b0;
            axi_rready      <= 1'b0;
            axi_awaddr      <= '0;
            axi_awvalid     <= 1'b0;
            axi_wdata       <= '0;
            axi_wstrb       <= '0;
            axi_wvalid      <= 1'b0;
            axi_bready      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_pend) begin
                        valid      <= '0;
                        flush_pend <= 1'b0;
                    end
                    if (request_enable) begin
                        cap.waddr    <= req_addr[31:2];
                        cap.uncached <= uncached;
                        if (req_mode == MEMREQ_READ) begin
                            if (hit) begin
                                resp_data       <= data_arr[idx];
                                response_enable <= 1'b1;
                                state           <= RESPOND;
                            end else begin
                                axi_araddr  <= {req_addr[31:2], 2'b00};
                                axi_arvalid <= 1'b1;
                                state       <= AR_WAIT;
                            end
                        end else begin
                            axi_awaddr  <= {req_addr[31:2], 2'b00};
                            axi_wdata   <= req_wdata;
                            axi_wstrb   <= req_wstrb;
                            axi_awvalid <= 1'b1;
                            axi_wvalid  <= 1'b1;
                            state       <= W_WAIT;
                        end
                    end
                end
                AR_WAIT: if (axi_arready) begin
                    axi_arvalid <= 1'b0;
                    axi_rready  <= 1'b1;
                    state       <= R_WAIT;
                end
                R_WAIT: if (axi_rvalid) begin
                    axi_rready      <= 1'b0;
                    resp_data       <= axi_rdata;
                    response_enable <= 1'b1;
                    if (fill_en) valid[fidx] <= 1'b1;
                    state           <= RESPOND;
                end
                W_WAIT: begin
                    // A dropped valid means that channel already handshook.
                    if (axi_awready) axi_awvalid <= 1'b0;
                    if (axi_wready)  axi_wvalid  <= 1'b0;
                    if ((!axi_awvalid || axi_awready) && (!axi_wvalid || axi_wready)) begin
                        axi_bready <= 1'b1;
                        state      <= B_WAIT;
                    end
                end
                B_WAIT: if (axi_bvalid) begin
                    axi_bready      <= 1'b0;
                    resp_data       <= '0;
                    response_enable <= 1'b1;
                    state           <= RESPOND;
                end
                RESPOND: begin
                    response_enable <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (flush) flush_pend <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dm_cache.sv
// Randomized self-checking bench for dm_cache: line-tracking reference model plus a stalling AXI4-Lite memory.
module tb_dm_cache;
    localparam int   NLINES = 256;
    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        request_enable = 1'b0, req_mode = 1'b0, flush = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        response_enable;
    logic [31:0] resp_data;
    logic [31:0] axi_araddr, axi_awaddr, axi_wdata;
    logic        axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready;
    logic [2:0]  axi_arprot, axi_awprot;
    logic [3:0]  axi_wstrb;
    logic        axi_arready = 1'b0, axi_rvalid = 1'b0, axi_awready = 1'b0, axi_wready = 1'b0, axi_bvalid = 1'b0;
    logic [31:0] axi_rdata = '0;
    logic [1:0]  axi_rresp = '0, axi_bresp = '0;

    dm_cache #(.NLINES(NLINES), .UNCACHED_PREFIX(4'hF)) dut (
        .clk(clk), .rstn(rstn), .request_enable(request_enable), .req_mode(req_mode),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .flush(flush),
        .response_enable(response_enable), .resp_data(resp_data),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arprot(axi_arprot), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awprot(axi_awprot), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0;

    // Reference: memory contents by word address, and which word each line holds.
    logic [31:0] mem [logic [29:0]];
    bit          lv [NLINES];
    logic [29:0] la [NLINES];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [29:0] w);
        if (mem.exists(w)) return mem[w];
        return {2'b10, w};
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic invalidate_all();
        for (int i = 0; i < NLINES; i++) lv[i] = 1'b0;
    endtask

    task automatic idle_slave();
        axi_arready = 0; axi_rvalid = 0; axi_rdata = '0; axi_rresp = '0;
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
    endtask

    // Drives one request and serves AXI with the given stall counts; ends one cycle after the response.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st,
                          input int ar_st, input int r_st, input int aw_st, input int w_st, input int b_st,
                          input logic [1:0] rr, input int fl_at,
                          output bit saw_ar, output int lat, output int nb, output logic [31:0] rd,
                          output bit ok, output bit fl_done);
        int arc = 0, rc = 0, awc = 0, wc = 0, bc = 0;
        bit pb = 0, aw_seen = 0;
        logic [31:0] rdv;
        rdv = (rr == 2'b00) ? mem_rd(addr[31:2]) : (32'hBAD0_0000 ^ addr);
        saw_ar = 0; lat = 0; nb = 0; rd = '0; ok = 0; fl_done = 0;
        request_enable = 1; req_mode = wr; req_addr = addr; req_wdata = wd; req_wstrb = st;
        while (!ok && lat < 200) begin
            @(posedge clk); #1;
            request_enable = 0;
            lat++;
            flush = (lat == fl_at);
            if (flush) fl_done = 1;
            if (axi_arvalid && !saw_ar) begin
                saw_ar = 1;
                chk("araddr", axi_araddr, {addr[31:2], 2'b00});
            end
            if (axi_awvalid && !aw_seen) begin
                aw_seen = 1;
                chk("awaddr", axi_awaddr, {addr[31:2], 2'b00});
                chk("wdata", axi_wdata, wd);
                chk("wstrb", {28'd0, axi_wstrb}, {28'd0, st});
            end
            if (axi_bready && !pb) nb++;
            pb = axi_bready;
            if (response_enable) begin ok = 1; rd = resp_data; end
            axi_arready = axi_arvalid && (arc == ar_st); if (axi_arvalid) arc++;
            axi_rvalid  = axi_rready  && (rc == r_st);   if (axi_rready)  rc++;
            axi_rdata   = axi_rvalid ? rdv : '0;
            axi_rresp   = rr;
            axi_awready = axi_awvalid && (awc == aw_st); if (axi_awvalid) awc++;
            axi_wready  = axi_wvalid  && (wc == w_st);   if (axi_wvalid)  wc++;
            axi_bvalid  = axi_bready  && (bc == b_st);   if (axi_bready)  bc++;
        end
        if (!ok) chk("timeout", 32'd0, 32'd1);
        idle_slave();
        @(posedge clk); #1;
        flush = 0;
        chk("pulse_width", {31'd0, response_enable}, 32'd0);
    endtask

    // One request checked against the reference model.
    task automatic op(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st,
                      input int ar_st, input int r_st, input int aw_st, input int w_st, input int b_st,
                      input logic [1:0] rr, input int fl_at);
        logic [29:0] w;
        int i, lat, nb;
        bit exp_hit, saw_ar, ok, fl_done;
        logic [31:0] rd, exp_d, m;
        w = addr[31:2];
        i = int'(w % NLINES);
        exp_hit = lv[i] && (la[i] == w);
        do_req(wr, addr, wd, st, ar_st, r_st, aw_st, w_st, b_st, rr, fl_at, saw_ar, lat, nb, rd, ok, fl_done);
        if (!wr) begin
            exp_d = (exp_hit || rr == 2'b00) ? mem_rd(w) : (32'hBAD0_0000 ^ addr);
            chk("rd_miss", {31'd0, saw_ar}, {31'd0, !exp_hit});
            chk("rd_data", rd, exp_d);
            chk("rd_lat", lat, exp_hit ? 1 : 3 + ar_st + r_st);
            if (!exp_hit && rr == 2'b00) begin lv[i] = 1; la[i] = w; end
        end else begin
            chk("wr_no_ar", {31'd0, saw_ar}, 32'd0);
            chk("wr_bphases", nb, 1);
            chk("wr_lat", lat, 3 + imax(aw_st, w_st) + b_st);
            m = mem_rd(w);
            for (int b = 0; b < 4; b++) if (st[b]) m[8*b +: 8] = wd[8*b +: 8];
            mem[w] = m;
        end
        if (fl_done) invalidate_all();
    endtask

    task automatic rd0(input logic [31:0] addr);
        op(RD, addr, '0, '0, 0, 0, 0, 0, 0, 2'b00, 0);
    endtask

    task automatic do_flush();
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        @(posedge clk); #1;
        invalidate_all();
    endtask

    initial begin
        int tmo;
        logic [29:0] wsel;
        invalidate_all();
        #1;
        chk("rst_resp", {31'd0, response_enable}, 32'd0);
        chk("rst_rdata", resp_data, 32'd0);
        chk("rst_valids", {27'd0, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}, 32'd0);
        chk("rst_addr", axi_araddr | axi_awaddr | axi_wdata, 32'd0);
        chk("rst_prot", {26'd0, axi_arprot, axi_awprot}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        @(posedge clk); #1;

        // Miss with stalls, then hit
        mem[30'h40] = 32'hDEADBEEF;
        op(RD, 32'h100, '0, '0, 3, 3, 0, 0, 0, 2'b00, 0);
        rd0(32'h100);
        // Conflict eviction
        rd0(32'h0); rd0(32'h400); rd0(32'h0);
        // Byte-merged write hit
        do_flush();
        mem[30'h40] = 32'h11223344;
        rd0(32'h100);
        op(WR, 32'h100, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 0, 1, 2'b00, 0);
        rd0(32'h100);
        chk("merge_val", mem_rd(30'h40), 32'h11BB33DD);
        op(WR, 32'h200, 32'h01020304, 4'hF, 0, 0, 1, 1, 0, 2'b00, 0);
        rd0(32'h200);
        // Write handshake orderings
        op(WR, 32'h104, 32'h55667788, 4'hF, 0, 0, 2, 0, 0, 2'b00, 0);
        op(WR, 32'h108, 32'h99AABBCC, 4'h3, 0, 0, 1, 1, 2, 2'b00, 0);
        // Flush while R_WAIT, then SLVERR read
        op(RD, 32'h300, '0, '0, 0, 3, 0, 0, 0, 2'b00, 3);
        rd0(32'h300);
        op(RD, 32'h500, '0, '0, 1, 0, 0, 0, 0, 2'b10, 0);
        rd0(32'h500);

        // Reset asserted while waiting for B
        request_enable = 1; req_mode = WR; req_addr = 32'h600; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
        tmo = 0;
        @(posedge clk); #1;
        request_enable = 0;
        axi_awready = 1; axi_wready = 1;
        @(posedge clk); #1;
        idle_slave();
        while (!axi_bready && tmo < 20) begin @(posedge clk); #1; tmo++; end
        chk("bwait_reached", {31'd0, axi_bready}, 32'd1);
        #1 rstn = 0;
        #1;
        chk("arst_outs", {26'd0, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready, response_enable}, 32'd0);
        axi_bvalid = 1;
        @(posedge clk); #1;
        chk("arst_noresp", {31'd0, response_enable}, 32'd0);
        axi_bvalid = 0;
        rstn = 1;
        mem[30'h180] = 32'hCAFEF00D;
        invalidate_all();
        @(posedge clk); #1;
        chk("post_rst_resp", {31'd0, response_enable}, 32'd0);
        rd0(32'h0);

        // Random traffic over a small conflicting address pool
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            logic [1:0] rr;
            int fl;
            wsel = (30'($urandom_range(0, 3)) << 8) | 30'($urandom_range(0, 7));
            a = {wsel, 2'b00};
            rr = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00;
            fl = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 4)) : 0;
            if ($urandom_range(0, 9) < 4)
                op(WR, a, $urandom, 4'($urandom_range(0, 15)), 0, 0,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 2'b00, fl);
            else
                op(RD, a, '0, '0, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0, rr, fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
